// File: rtl/apb2_pkg.sv
// Shared definitions for the APB2 command master: FSM state encoding and bus constants.
package apb2_pkg;

  // IDLE is encoded as zero so that an all-zero reset value is an idle controller.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb2_master_state_t;

  localparam logic [2:0] APB2_PPROT_DEFAULT = 3'b000;

  localparam int APB2_WAIT_CNT_W = 16;

endpackage

// File: rtl/apb2_cmd_master_if.sv
// Command/response handshake plus APB bus bundle for the APB2 command master.
interface apb2_cmd_master_if #(
  parameter int data_width = 32,
  parameter int addr_width = 8
);
  localparam int strb_width = data_width / 8;

  // command channel
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [addr_width-1:0] cmd_addr;
  logic [data_width-1:0] cmd_wdata;
  logic [strb_width-1:0] cmd_strb;

  // response channel
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [data_width-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;

  // APB request
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [addr_width-1:0] paddr;
  logic [data_width-1:0] pwdata;
  logic [strb_width-1:0] pstrb;
  logic [2:0]            pprot;

  // APB completion
  logic [data_width-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    input  rsp_ready,
    input  prdata, pready, pslverr,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
    output rsp_ready,
    output prdata, pready, pslverr,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot
  );

endinterface

// File: rtl/apb2_wait_timer.sv
// Saturating ACCESS-phase wait counter; flags the wait cycle that reaches the limit.
module apb2_wait_timer (
  input  logic        pclk,
  input  logic        preset_n,
  input  logic        clear,
  input  logic        enable,
  input  logic [15:0] limit,
  output logic        expired
);

  logic [15:0] cnt;

  // count wait cycles, clear wins, hold at all-ones instead of wrapping
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n)                      cnt <= '0;
    else if (clear)                     cnt <= '0;
    else if (enable && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
  end

  // the wait cycle in progress is the one that takes the count to the limit
  assign expired = enable && (({1'b0, cnt} + 17'd1) >= {1'b0, limit});

endmodule

// File: rtl/apb2_cmd_master.sv
// APB2 master: turns one command into one APB transfer and returns one response.
module apb2_cmd_master
  import apb2_pkg::*;
#(
  parameter int data_width     = 32,
  parameter int addr_width     = 8,
  parameter int timeout_cycles = 255
) (
  input logic               pclk,
  input logic               preset_n,
  apb2_cmd_master_if.master bus
);

  localparam int strb_width = data_width / 8;
  localparam logic [APB2_WAIT_CNT_W-1:0] tmo_limit = APB2_WAIT_CNT_W'(timeout_cycles);

  // every output is a flop; the whole registered set lives in one struct
  typedef struct packed {
    apb2_master_state_t    state;
    logic                  cmd_ready;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [addr_width-1:0] paddr;
    logic [data_width-1:0] pwdata;
    logic [strb_width-1:0] pstrb;
    logic                  rsp_valid;
    logic [data_width-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;
  } ctl_t;

  ctl_t q, d;
  logic accept;
  logic tmo_clear;
  logic tmo_en;
  logic tmo_expired;

  assign accept = bus.cmd_valid && q.cmd_ready;
  assign tmo_en = (q.state == ACCESS) && !bus.pready;

  apb2_wait_timer u_wait_timer (
    .pclk     (pclk),
    .preset_n (preset_n),
    .clear    (tmo_clear),
    .enable   (tmo_en),
    .limit    (tmo_limit),
    .expired  (tmo_expired)
  );

  // state and output registers; all-zero is IDLE with the bus parked
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) q <= '0;
    else           q <= d;
  end

  // next state and next registered outputs
  always_comb begin
    d           = q;
    d.cmd_ready = 1'b0;
    tmo_clear   = 1'b0;
    case (q.state)
      IDLE: begin
        if (accept) begin
          if (bus.cmd_addr[1:0] == 2'b00) begin
            d.state   = SETUP;
            d.psel    = 1'b1;
            d.penable = 1'b0;
            d.pwrite  = bus.cmd_write;
            d.paddr   = bus.cmd_addr;
            d.pwdata  = bus.cmd_wdata;
            d.pstrb   = bus.cmd_write ? bus.cmd_strb : '0;
            tmo_clear = 1'b1;
          end else begin
            // misaligned: answer with an error, never touch the bus
            d.state       = RESP;
            d.rsp_valid   = 1'b1;
            d.rsp_rdata   = '0;
            d.rsp_err     = 1'b1;
            d.rsp_timeout = 1'b0;
          end
        end else begin
          d.cmd_ready = 1'b1;
        end
      end
      SETUP: begin
        d.state   = ACCESS;
        d.penable = 1'b1;
      end
      ACCESS: begin
        if (bus.pready) begin
          d.state       = RESP;
          d.psel        = 1'b0;
          d.penable     = 1'b0;
          d.rsp_valid   = 1'b1;
          d.rsp_rdata   = q.pwrite ? '0 : bus.prdata;
          d.rsp_err     = bus.pslverr;
          d.rsp_timeout = 1'b0;
        end else if (tmo_expired) begin
          d.state       = RESP;
          d.psel        = 1'b0;
          d.penable     = 1'b0;
          d.rsp_valid   = 1'b1;
          d.rsp_rdata   = '0;
          d.rsp_err     = 1'b1;
          d.rsp_timeout = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          d.state     = IDLE;
          d.rsp_valid = 1'b0;
          d.cmd_ready = 1'b1;
        end
      end
      default: d.state = IDLE;
    endcase
  end

  assign bus.cmd_ready   = q.cmd_ready;
  assign bus.psel        = q.psel;
  assign bus.penable     = q.penable;
  assign bus.pwrite      = q.pwrite;
  assign bus.paddr       = q.paddr;
  assign bus.pwdata      = q.pwdata;
  assign bus.pstrb       = q.pstrb;
  assign bus.pprot       = APB2_PPROT_DEFAULT;
  assign bus.rsp_valid   = q.rsp_valid;
  assign bus.rsp_rdata   = q.rsp_rdata;
  assign bus.rsp_err     = q.rsp_err;
  assign bus.rsp_timeout = q.rsp_timeout;

endmodule

// File: tb/tb_apb2_cmd_master.sv
// Scoreboard bench for apb2_cmd_master: random commands, modelled APB slave, response monitor.
module tb_apb2_cmd_master;

  localparam int DW  = 32;
  localparam int AW  = 8;
  localparam int TMO = 4;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    strb;
    int            waits;
    logic          slverr;
    logic [DW-1:0] prdata;
  } cmd_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          tmo;
    int            cyc;
  } exp_t;

  logic pclk;
  logic preset_n;
  int   cyc;
  int   total;
  int   bad;
  int   n_rsp;

  cmd_t slv_q[$];
  exp_t exp_q[$];

  apb2_cmd_master_if #(.data_width(DW), .addr_width(AW)) bus ();

  apb2_cmd_master #(.data_width(DW), .addr_width(AW), .timeout_cycles(TMO)) dut (
    .pclk     (pclk),
    .preset_n (preset_n),
    .bus      (bus)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  initial cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // what the command should produce, from the block's rules alone
  function automatic exp_t model(input cmd_t c, input int acc);
    exp_t e;
    if (c.addr[1:0] != 2'b00) begin
      e.rdata = '0; e.err = 1'b1; e.tmo = 1'b0; e.cyc = acc + 1;
    end else if (c.waits >= TMO) begin
      e.rdata = '0; e.err = 1'b1; e.tmo = 1'b1; e.cyc = acc + 3 + (TMO - 1);
    end else begin
      e.rdata = c.write ? '0 : c.prdata;
      e.err = c.slverr; e.tmo = 1'b0; e.cyc = acc + 3 + c.waits;
    end
    return e;
  endfunction

  // ---------------- APB slave model ----------------
  cmd_t cur;
  bit   have_cur;

  task automatic check_req(input string tag);
    check({tag, "_paddr"}, bus.paddr, cur.addr);
    check({tag, "_pwrite"}, bus.pwrite, cur.write);
    check({tag, "_pstrb"}, bus.pstrb, cur.write ? cur.strb : 4'h0);
    if (cur.write) check({tag, "_pwdata"}, bus.pwdata, cur.wdata);
    check({tag, "_pprot"}, bus.pprot, 3'b000);
  endtask

  initial begin
    int k;
    k = 0;
    have_cur = 0;
    bus.pready = 1'b0; bus.pslverr = 1'b0; bus.prdata = '0;
    forever begin
      @(negedge pclk);
      if (!preset_n) begin
        k = 0; have_cur = 0; bus.pready = 1'b0;
        continue;
      end
      if (bus.penable && !bus.psel) check("penable_wo_psel", 1'b1, 1'b0);
      if (bus.psel && !bus.penable) begin
        if (slv_q.size() == 0) begin
          check("spurious_psel", 1'b1, 1'b0);
          have_cur = 0;
        end else begin
          cur = slv_q.pop_front();
          have_cur = 1;
          check_req("setup");
        end
        k = 0;
      end
      if (bus.psel && bus.penable && have_cur) begin
        k++;
        check_req("access");
        if (k > TMO) check("access_len", k, TMO);
        if (k == cur.waits + 1) begin
          bus.pready = 1'b1; bus.pslverr = cur.slverr; bus.prdata = cur.prdata;
        end else begin
          bus.pready = 1'b0; bus.pslverr = 1'($urandom); bus.prdata = $urandom;
        end
      end else begin
        // garbage outside ACCESS must be ignored
        if (!bus.psel) k = 0;
        bus.pready = 1'($urandom); bus.pslverr = 1'($urandom); bus.prdata = $urandom;
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin
    exp_t e;
    bit   prev_v;
    bit   have_e;
    int   hold;
    prev_v = 0; have_e = 0; hold = 0; n_rsp = 0;
    bus.rsp_ready = 1'b0;
    forever begin
      @(negedge pclk);
      if (!preset_n) begin
        prev_v = 0; have_e = 0; bus.rsp_ready = 1'b0;
        continue;
      end
      if (bus.rsp_valid) begin
        if (!prev_v) begin
          if (exp_q.size() == 0) begin
            check("spurious_rsp", 1'b1, 1'b0);
            have_e = 0;
          end else begin
            e = exp_q.pop_front();
            have_e = 1;
            check("rsp_cycle", cyc, e.cyc);
          end
          hold = (n_rsp == 1) ? 5 : $urandom_range(0, 3);
          n_rsp++;
        end
        if (have_e) begin
          check("rsp_rdata", bus.rsp_rdata, e.rdata);
          check("rsp_err", bus.rsp_err, e.err);
          check("rsp_timeout", bus.rsp_timeout, e.tmo);
        end
        check("cmd_ready_in_resp", bus.cmd_ready, 1'b0);
        check("psel_in_resp", bus.psel, 1'b0);
        bus.rsp_ready = (hold == 0);
        if (hold > 0) hold--;
      end else begin
        bus.rsp_ready = 1'($urandom);
      end
      prev_v = bus.rsp_valid;
    end
  end

  // ---------------- stimulus ----------------
  // called just after a negedge; returns one negedge after acceptance
  task automatic issue(input cmd_t c);
    int   guard;
    exp_t e;
    guard = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = c.write;
    bus.cmd_addr  = c.addr;
    bus.cmd_wdata = c.wdata;
    bus.cmd_strb  = c.strb;
    while (!bus.cmd_ready && guard < 200) begin
      @(negedge pclk);
      guard++;
    end
    if (guard >= 200) begin
      check("accept_timeout", 1'b0, 1'b1);
    end else begin
      e = model(c, cyc);
      exp_q.push_back(e);
      if (c.addr[1:0] == 2'b00) slv_q.push_back(c);
    end
    @(negedge pclk);
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.write  = 1'($urandom);
    c.addr   = AW'($urandom);
    if ($urandom_range(0, 3) != 0) c.addr[1:0] = 2'b00;
    c.wdata  = $urandom;
    c.strb   = 4'($urandom);
    c.waits  = $urandom_range(0, 6);
    c.slverr = 1'($urandom);
    c.prdata = $urandom;
    return c;
  endfunction

  function automatic cmd_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                              input logic [3:0] s, input int wt, input logic se, input logic [DW-1:0] rd);
    cmd_t c;
    c.write = w; c.addr = a; c.wdata = wd; c.strb = s;
    c.waits = wt; c.slverr = se; c.prdata = rd;
    return c;
  endfunction

  task automatic idle_gap();
    int g;
    g = $urandom_range(0, 3);
    if (g != 0) begin
      bus.cmd_valid = 1'b0;
      repeat (g) @(negedge pclk);
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    bus.cmd_valid = 1'b0;
    while ((exp_q.size() != 0 || bus.rsp_valid) && guard < 500) begin
      @(negedge pclk);
      guard++;
    end
    check("drain_exp", exp_q.size(), 0);
    check("drain_slv", slv_q.size(), 0);
    repeat (3) @(negedge pclk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_psel"}, bus.psel, 1'b0);
    check({tag, "_penable"}, bus.penable, 1'b0);
    check({tag, "_pwrite"}, bus.pwrite, 1'b0);
    check({tag, "_paddr"}, bus.paddr, '0);
    check({tag, "_pwdata"}, bus.pwdata, '0);
    check({tag, "_pstrb"}, bus.pstrb, '0);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
    check({tag, "_rsp_err"}, bus.rsp_err, 1'b0);
    check({tag, "_rsp_timeout"}, bus.rsp_timeout, 1'b0);
    check({tag, "_rsp_rdata"}, bus.rsp_rdata, '0);
    check({tag, "_cmd_ready"}, bus.cmd_ready, 1'b0);
  endtask

  initial begin
    int guard;
    total = 0; bad = 0;
    preset_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
    bus.cmd_wdata = '0; bus.cmd_strb = '0;

    repeat (2) @(negedge pclk);
    check_reset_outputs("rst");
    #2 preset_n = 1'b1;
    @(negedge pclk);
    check("cmd_ready_after_rst", bus.cmd_ready, 1'b1);

    // directed: clean read, slow erroring write, timeout, misaligned
    issue(mk(1'b0, 8'h00, 32'h0, 4'h0, 0, 1'b0, 32'h0000_00A5));
    issue(mk(1'b1, 8'h04, 32'hDEAD_BEEF, 4'hF, 3, 1'b1, 32'h1234_5678));
    issue(mk(1'b0, 8'h08, 32'h0, 4'h0, 100, 1'b0, 32'hCAFE_F00D));
    issue(mk(1'b0, 8'h06, 32'h0, 4'h0, 0, 1'b0, 32'h5555_AAAA));
    // exactly one wait short of the limit still completes
    issue(mk(1'b0, 8'h0C, 32'h0, 4'h0, TMO - 1, 1'b0, 32'h0BAD_CAFE));

    for (int i = 0; i < 60; i++) begin
      issue(rand_cmd());
      idle_gap();
    end
    drain();

    // reset in the middle of ACCESS abandons the transfer
    issue(mk(1'b0, 8'h10, 32'h0, 4'h0, 100, 1'b0, 32'h0));
    guard = 0;
    while (!bus.penable && guard < 20) begin
      @(negedge pclk);
      guard++;
    end
    check("reached_access", bus.penable, 1'b1);
    #2 preset_n = 1'b0;
    #1;
    check("arst_psel", bus.psel, 1'b0);
    check("arst_penable", bus.penable, 1'b0);
    check("arst_rsp_valid", bus.rsp_valid, 1'b0);
    check("arst_cmd_ready", bus.cmd_ready, 1'b0);
    exp_q.delete();
    slv_q.delete();
    bus.cmd_valid = 1'b0;
    @(negedge pclk);
    #2 preset_n = 1'b1;
    @(negedge pclk);
    check("cmd_ready_after_arst", bus.cmd_ready, 1'b1);
    repeat (4) @(negedge pclk);

    for (int i = 0; i < 15; i++) begin
      issue(rand_cmd());
      idle_gap();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb2_cmd_master.md
APB2_CMD_MASTER -- requirements
Module: apb2_cmd_master

Interface
REQ-001 SHALL have parameter data_width, default 32, APB data width in bits.
REQ-002 SHALL have parameter addr_width, default 8, APB byte address width.
REQ-003 SHALL have parameter timeout_cycles, default 255, maximum ACCESS-phase wait cycles before abort (1..65535).
REQ-004 SHALL have port pclk  in  1  clock; all logic on rising edge.
REQ-005 SHALL have port preset_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports cmd_valid in 1 / cmd_ready out 1: command handshake.
REQ-007 SHALL have ports cmd_write in 1, cmd_addr in addr_width, cmd_wdata in data_width, cmd_strb in data_width/8: command payload.
REQ-008 SHALL have ports rsp_valid out 1 / rsp_ready in 1: response handshake.
REQ-009 SHALL have ports rsp_rdata out data_width, rsp_err out 1, rsp_timeout out 1: response payload.
REQ-010 SHALL have ports psel, penable, pwrite out 1; paddr out addr_width; pwdata out data_width; pstrb out data_width/8; pprot out 3: APB request.
REQ-011 SHALL have ports prdata in data_width, pready in 1, pslverr in 1: APB completion.

Function
REQ-012 SHALL implement states IDLE, SETUP, ACCESS, RESP; all outputs registered.
REQ-013 cmd_ready SHALL be 1 only in IDLE; command accepted when cmd_valid && cmd_ready.
REQ-014 On acceptance with cmd_addr[1:0]==0: latch payload into paddr/pwrite/pwdata/pstrb, next state SETUP (psel=1, penable=0).
REQ-015 On acceptance with cmd_addr[1:0]!=0: no bus activity; next state RESP with rsp_err=1, rsp_timeout=0, rsp_rdata=0.
REQ-016 SETUP SHALL last exactly one cycle, then ACCESS (psel=1, penable=1); paddr/pwrite/pwdata/pstrb stable SETUP through ACCESS end.
REQ-017 In ACCESS with pready=1: rsp_rdata=prdata for reads, 0 for writes; rsp_err=pslverr; rsp_timeout=0; psel=penable=0 next cycle; go RESP.
REQ-018 In ACCESS with pready=0: increment 16-bit wait counter; when counter equals timeout_cycles, abort: psel=penable=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0, go RESP.
REQ-019 Wait counter SHALL clear on entry to SETUP; saturates, never wraps.
REQ-020 Latency: accept at cycle N, SETUP N+1, ACCESS N+2, rsp_valid at N+3 when pready=1 in first ACCESS cycle.
REQ-021 RESP: rsp_valid=1, payload held stable until rsp_valid && rsp_ready; then rsp_valid=0, go IDLE (cmd_ready=1 same cycle as rsp_valid falls).
REQ-022 pprot SHALL be constant 3'b000; pstrb SHALL be 0 for reads.
REQ-023 Outside SETUP/ACCESS psel=penable=0; pready/pslverr ignored outside ACCESS.
REQ-024 Only one outstanding transaction; cmd_valid asserted outside IDLE has no effect.

Reset
REQ-025 On preset_n=0, immediately: state IDLE, psel=penable=pwrite=0, paddr=pwdata=pstrb=0, rsp_valid=rsp_err=rsp_timeout=0, rsp_rdata=0, wait counter 0; cmd_ready=0 during reset, 1 first cycle after release.
REQ-026 Reset mid-transaction SHALL abandon it with no response generated.

Structure
REQ-027 Shared package apb2_pkg SHALL hold the state enum apb2_master_state_t and constant APB2_PPROT_DEFAULT (3'b000).
REQ-028 Wait-timeout counter SHALL be one sub-module apb2_wait_timer (clear, enable, limit in; expired out); no other sub-modules.

Verification
REQ-029 Read addr 0x00, slave pready=1 first ACCESS, prdata=0x0000_00A5 -> SETUP cycle 1, ACCESS cycle 2, rsp_valid cycle 3, rsp_rdata=0xA5, rsp_err=0.
REQ-030 Write addr 0x04 data 0xDEAD_BEEF strb 4'hF, pready after 3 wait cycles, pslverr=1 -> pwdata/paddr stable throughout, rsp_err=1, rsp_timeout=0, rsp_rdata=0.
REQ-031 timeout_cycles=4, pready held 0 -> psel drops after 4 ACCESS wait cycles, rsp_err=1, rsp_timeout=1.
REQ-032 Command addr 0x06 -> no psel pulse, rsp_valid 1 cycle after acceptance, rsp_err=1.
REQ-033 rsp_ready held 0 for 5 cycles while new cmd_valid=1 -> cmd_ready stays 0, payload stable, second command starts only after response accepted.
REQ-034 preset_n pulsed low during ACCESS -> psel/penable/rsp_valid 0 asynchronously, no response, next command completes normally.
